// File: rtl/sdram_burst_sched.sv
// ============================================================================
// sdram_burst_sched : FIFO-level driven write/read burst scheduler for SDRAM
// Revision: 1.0
// ============================================================================
`default_nettype none

module sdram_burst_sched #(
  parameter int ADDR_W      = 24,
  parameter int LEN_W       = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sdram_init_done,
  input  logic [LEN_W-1:0]  wr_fifo_used,
  input  logic [LEN_W-1:0]  rd_fifo_used,
  input  logic [LEN_W-1:0]  wr_burst,
  input  logic [LEN_W-1:0]  rd_burst,
  input  logic [ADDR_W-1:0] wr_min_addr,
  input  logic [ADDR_W-1:0] wr_max_addr,
  input  logic [ADDR_W-1:0] rd_min_addr,
  input  logic [ADDR_W-1:0] rd_max_addr,
  input  logic              wr_load,
  input  logic              rd_load,
  input  logic              read_valid,
  input  logic              sdram_wr_ack,
  input  logic              sdram_rd_ack,
  output logic              sdram_wr_req,
  output logic              sdram_rd_req,
  output logic [ADDR_W-1:0] sdram_wr_addr,
  output logic [ADDR_W-1:0] sdram_rd_addr,
  output logic              wr_fifo_flush,
  output logic              rd_fifo_flush
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR_REQ = 3'd1,
    S_WR_RUN = 3'd2,
    S_RD_REQ = 3'd3,
    S_RD_RUN = 3'd4
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] wr_sync_q;
  logic [SYNC_STAGES-1:0] rd_sync_q;
  logic                   wr_prev_q;
  logic                   rd_prev_q;
  logic                   wr_pend_q;
  logic                   rd_pend_q;
  logic                   init_seen_q;
  logic                   wr_req_q;
  logic                   rd_req_q;
  logic                   wr_flush_q;
  logic                   rd_flush_q;
  logic [ADDR_W-1:0]      wr_addr_q;
  logic [ADDR_W-1:0]      rd_addr_q;

  logic                   wr_load_rise;
  logic                   rd_load_rise;
  logic [ADDR_W:0]        wr_sum;
  logic [ADDR_W:0]        rd_sum;
  logic [ADDR_W-1:0]      wr_next_d;
  logic [ADDR_W-1:0]      rd_next_d;

  assign wr_load_rise = wr_sync_q[SYNC_STAGES-1] & ~wr_prev_q;
  assign rd_load_rise = rd_sync_q[SYNC_STAGES-1] & ~rd_prev_q;

  // One extra bit keeps the sum from wrapping before the region-end compare
  assign wr_sum    = {1'b0, wr_addr_q} + {{(ADDR_W+1-LEN_W){1'b0}}, wr_burst};
  assign rd_sum    = {1'b0, rd_addr_q} + {{(ADDR_W+1-LEN_W){1'b0}}, rd_burst};
  assign wr_next_d = (wr_sum >= {1'b0, wr_max_addr}) ? wr_min_addr : wr_sum[ADDR_W-1:0];
  assign rd_next_d = (rd_sum >= {1'b0, rd_max_addr}) ? rd_min_addr : rd_sum[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sync_q <= '0;
      rd_sync_q <= '0;
      wr_prev_q <= 1'b0;
      rd_prev_q <= 1'b0;
    end else begin
      wr_sync_q[0] <= wr_load;
      rd_sync_q[0] <= rd_load;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        wr_sync_q[i] <= wr_sync_q[i-1];
        rd_sync_q[i] <= rd_sync_q[i-1];
      end
      wr_prev_q <= wr_sync_q[SYNC_STAGES-1];
      rd_prev_q <= rd_sync_q[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_pend_q   <= 1'b0;
      rd_pend_q   <= 1'b0;
      init_seen_q <= 1'b0;
      wr_req_q    <= 1'b0;
      rd_req_q    <= 1'b0;
      wr_flush_q  <= 1'b0;
      rd_flush_q  <= 1'b0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
    end else begin
      wr_flush_q <= 1'b0;
      rd_flush_q <= 1'b0;

      // A pointer not owned by a running burst reloads at once; otherwise defer
      if (wr_load_rise) begin
        if (state_q == S_WR_RUN) begin
          wr_pend_q <= 1'b1;
        end else begin
          wr_addr_q  <= wr_min_addr;
          wr_flush_q <= 1'b1;
        end
      end
      if (rd_load_rise) begin
        if (state_q == S_RD_RUN) begin
          rd_pend_q <= 1'b1;
        end else begin
          rd_addr_q  <= rd_min_addr;
          rd_flush_q <= 1'b1;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (sdram_init_done) begin
            if (!init_seen_q) begin
              init_seen_q <= 1'b1;
              wr_addr_q   <= wr_min_addr;
              rd_addr_q   <= rd_min_addr;
            end
            if (!(wr_load_rise || rd_load_rise)) begin
              if (wr_fifo_used >= wr_burst) begin
                wr_req_q <= 1'b1;
                state_q  <= S_WR_REQ;
              end else if (read_valid && (rd_fifo_used < rd_burst)) begin
                rd_req_q <= 1'b1;
                state_q  <= S_RD_REQ;
              end
            end
          end
        end

        S_WR_REQ: begin
          if (wr_load_rise) begin
            wr_req_q <= 1'b0;
            state_q  <= S_IDLE;
          end else if (sdram_wr_ack) begin
            wr_req_q <= 1'b0;
            state_q  <= S_WR_RUN;
          end
        end

        S_WR_RUN: begin
          if (!sdram_wr_ack) begin
            state_q <= S_IDLE;
            if (wr_pend_q || wr_load_rise) begin
              wr_addr_q  <= wr_min_addr;
              wr_flush_q <= 1'b1;
              wr_pend_q  <= 1'b0;
            end else begin
              wr_addr_q <= wr_next_d;
            end
          end
        end

        S_RD_REQ: begin
          if (rd_load_rise) begin
            rd_req_q <= 1'b0;
            state_q  <= S_IDLE;
          end else if (sdram_rd_ack) begin
            rd_req_q <= 1'b0;
            state_q  <= S_RD_RUN;
          end
        end

        S_RD_RUN: begin
          if (!sdram_rd_ack) begin
            state_q <= S_IDLE;
            if (rd_pend_q || rd_load_rise) begin
              rd_addr_q  <= rd_min_addr;
              rd_flush_q <= 1'b1;
              rd_pend_q  <= 1'b0;
            end else begin
              rd_addr_q <= rd_next_d;
            end
          end
        end

        default: begin
          wr_req_q <= 1'b0;
          rd_req_q <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign sdram_wr_req  = wr_req_q;
  assign sdram_rd_req  = rd_req_q;
  assign sdram_wr_addr = wr_addr_q;
  assign sdram_rd_addr = rd_addr_q;
  assign wr_fifo_flush = wr_flush_q;
  assign rd_fifo_flush = rd_flush_q;

endmodule

`default_nettype wire

// File: tb/tb_sdram_burst_sched.sv
// ============================================================================
// tb_sdram_burst_sched : directed self-checking bench for sdram_burst_sched
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sdram_burst_sched;
  localparam int AW = 24;
  localparam int LW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sdram_init_done;
  logic [LW-1:0] wr_fifo_used, rd_fifo_used, wr_burst, rd_burst;
  logic [AW-1:0] wr_min_addr, wr_max_addr, rd_min_addr, rd_max_addr;
  logic          wr_load, rd_load, read_valid, sdram_wr_ack, sdram_rd_ack;
  logic          sdram_wr_req, sdram_rd_req, wr_fifo_flush, rd_fifo_flush;
  logic [AW-1:0] sdram_wr_addr, sdram_rd_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sdram_burst_sched #(.ADDR_W(AW), .LEN_W(LW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sdram_init_done(sdram_init_done),
    .wr_fifo_used(wr_fifo_used), .rd_fifo_used(rd_fifo_used),
    .wr_burst(wr_burst), .rd_burst(rd_burst),
    .wr_min_addr(wr_min_addr), .wr_max_addr(wr_max_addr),
    .rd_min_addr(rd_min_addr), .rd_max_addr(rd_max_addr),
    .wr_load(wr_load), .rd_load(rd_load), .read_valid(read_valid),
    .sdram_wr_ack(sdram_wr_ack), .sdram_rd_ack(sdram_rd_ack),
    .sdram_wr_req(sdram_wr_req), .sdram_rd_req(sdram_rd_req),
    .sdram_wr_addr(sdram_wr_addr), .sdram_rd_addr(sdram_rd_addr),
    .wr_fifo_flush(wr_fifo_flush), .rd_fifo_flush(rd_fifo_flush)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_wr_req(output bit ok);
    int n = 0;
    ok = 0;
    while (!ok && n < 64) begin
      if (sdram_wr_req === 1'b1) ok = 1;
      else begin tick(); n++; end
    end
  endtask

  task automatic wait_rd_req(output bit ok);
    int n = 0;
    ok = 0;
    while (!ok && n < 64) begin
      if (sdram_rd_req === 1'b1) ok = 1;
      else begin tick(); n++; end
    end
  endtask

  task automatic wr_burst_ack(input int n);
    sdram_wr_ack = 1'b1;
    repeat (n) tick();
    sdram_wr_ack = 1'b0;
    tick();
  endtask

  task automatic rd_burst_ack(input int n);
    sdram_rd_ack = 1'b1;
    repeat (n) tick();
    sdram_rd_ack = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({sdram_wr_req, sdram_rd_req, wr_fifo_flush, rd_fifo_flush} !== 4'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b expected 0000",
                      {sdram_wr_req, sdram_rd_req, wr_fifo_flush, rd_fifo_flush});
    end
    total++;
    if (sdram_wr_addr !== 24'h0 || sdram_rd_addr !== 24'h0) begin
      bad++; $display("FAIL reset_addr: got %0h/%0h expected 0/0", sdram_wr_addr, sdram_rd_addr);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_init();
    bit ok;
    int reqs = 0;
    wr_fifo_used = 10'd512;
    for (int i = 0; i < 6; i++) begin
      tick();
      reqs += int'(sdram_wr_req) + int'(sdram_rd_req);
    end
    total++;
    if (reqs !== 0) begin bad++; $display("FAIL preinit_req: got %0d requests expected 0", reqs); end
    sdram_init_done = 1'b1;
    wait_wr_req(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL init_wr_req: got timeout expected request"); end
    total++;
    if (sdram_wr_addr !== 24'h0) begin bad++; $display("FAIL init_wr_addr: got %0h expected 0", sdram_wr_addr); end
    total++;
    if (sdram_rd_addr !== 24'h1000) begin bad++; $display("FAIL init_rd_addr: got %0h expected 1000", sdram_rd_addr); end
    wr_burst_ack(256);
    total++;
    if (sdram_wr_addr !== 24'd256) begin bad++; $display("FAIL first_advance: got %0h expected 100", sdram_wr_addr); end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [AW-1:0] wexp [3];
    logic [AW-1:0] rexp [4];
    wexp = '{24'd256, 24'd512, 24'd0};
    rexp = '{24'h1000, 24'h1100, 24'h1200, 24'h1000};
    for (int i = 0; i < 3; i++) begin
      wait_wr_req(ok);
      total++;
      if (!ok || sdram_wr_addr !== wexp[i]) begin
        bad++; $display("FAIL wr_wrap_%0d: got ok=%0d addr=%0h expected %0h", i, ok, sdram_wr_addr, wexp[i]);
      end
      wr_burst_ack(4);
    end
    wr_fifo_used = 10'd0;
    rd_fifo_used = 10'd0;
    read_valid   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_rd_req(ok);
      total++;
      if (!ok || sdram_rd_addr !== rexp[i] || sdram_wr_req !== 1'b0) begin
        bad++; $display("FAIL rd_wrap_%0d: got ok=%0d addr=%0h wreq=%b expected %0h", i, ok,
                        sdram_rd_addr, sdram_wr_req, rexp[i]);
      end
      rd_burst_ack(4);
    end
    rd_fifo_used = 10'd512;
    tick();
    total++;
    if (sdram_rd_addr !== 24'h1100 || sdram_wr_addr !== 24'd256) begin
      bad++; $display("FAIL wrap_final: got %0h/%0h expected 100/1100", sdram_wr_addr, sdram_rd_addr);
    end
  endtask

  task automatic test_priority();
    bit ok;
    tick();
    wr_fifo_used = 10'd300;
    rd_fifo_used = 10'd0;
    tick();
    total++;
    if (sdram_wr_req !== 1'b1 || sdram_rd_req !== 1'b0) begin
      bad++; $display("FAIL priority: got wreq=%b rreq=%b expected 1 0", sdram_wr_req, sdram_rd_req);
    end
    wr_fifo_used = 10'd0;
    wr_burst_ack(6);
    total++;
    if (sdram_rd_req !== 1'b0 || sdram_wr_addr !== 24'd512) begin
      bad++; $display("FAIL idle_gap: got rreq=%b waddr=%0h expected 0 200", sdram_rd_req, sdram_wr_addr);
    end
    wait_rd_req(ok);
    total++;
    if (!ok || sdram_rd_addr !== 24'h1100) begin
      bad++; $display("FAIL read_after_write: got ok=%0d addr=%0h expected 1100", ok, sdram_rd_addr);
    end
    rd_burst_ack(3);
    rd_fifo_used = 10'd512;
  endtask

  task automatic test_load_run();
    bit ok;
    int fl = 0;
    int moved = 0;
    wr_max_addr  = 24'd1024;
    wr_fifo_used = 10'd512;
    wait_wr_req(ok);
    total++;
    if (!ok || sdram_wr_addr !== 24'd512) begin
      bad++; $display("FAIL load_run_req: got ok=%0d addr=%0h expected 200", ok, sdram_wr_addr);
    end
    sdram_wr_ack = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      if (i == 1 || i == 8) wr_load = 1'b1;
      if (i == 5 || i == 12) wr_load = 1'b0;
      tick();
      fl += int'(wr_fifo_flush);
      if (sdram_wr_addr !== 24'd512) moved++;
    end
    total++;
    if (fl !== 0 || moved !== 0) begin
      bad++; $display("FAIL load_during_run: got flush=%0d moved=%0d expected 0 0", fl, moved);
    end
    wr_fifo_used = 10'd0;
    sdram_wr_ack = 1'b0;
    fl = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      fl += int'(wr_fifo_flush);
    end
    total++;
    if (fl !== 1) begin bad++; $display("FAIL load_flush_count: got %0d expected 1", fl); end
    total++;
    if (sdram_wr_addr !== 24'd0) begin bad++; $display("FAIL load_reload_addr: got %0h expected 0", sdram_wr_addr); end
    wr_max_addr = 24'd768;
  endtask

  task automatic test_load_req();
    bit ok;
    int fl = 0;
    bit seen = 0;
    rd_fifo_used = 10'd0;
    wait_rd_req(ok);
    total++;
    if (!ok || sdram_rd_addr !== 24'h1200) begin
      bad++; $display("FAIL rd_req_before_load: got ok=%0d addr=%0h expected 1200", ok, sdram_rd_addr);
    end
    rd_load = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rd_fifo_flush === 1'b1) begin
        fl++;
        if (!seen) begin
          seen = 1;
          total++;
          if (sdram_rd_req !== 1'b0 || sdram_rd_addr !== 24'h1000) begin
            bad++; $display("FAIL rd_withdraw: got req=%b addr=%0h expected 0 1000", sdram_rd_req, sdram_rd_addr);
          end
        end
      end
    end
    rd_load = 1'b0;
    total++;
    if (fl !== 1) begin bad++; $display("FAIL rd_flush_count: got %0d expected 1", fl); end
    wait_rd_req(ok);
    total++;
    if (!ok || sdram_rd_addr !== 24'h1000) begin
      bad++; $display("FAIL rd_new_req: got ok=%0d addr=%0h expected 1000", ok, sdram_rd_addr);
    end
    rd_burst_ack(3);
    rd_fifo_used = 10'd512;
  endtask

  task automatic test_block_and_reset();
    bit ok;
    int rq = 0;
    read_valid   = 1'b0;
    rd_fifo_used = 10'd0;
    for (int i = 0; i < 10; i++) begin
      tick();
      rq += int'(sdram_rd_req);
    end
    total++;
    if (rq !== 0) begin bad++; $display("FAIL read_blocked: got %0d read requests expected 0", rq); end
    wr_fifo_used = 10'd512;
    wait_wr_req(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL reset_pre_req: got timeout expected request"); end
    sdram_wr_ack = 1'b1;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({sdram_wr_req, sdram_rd_req, wr_fifo_flush, rd_fifo_flush} !== 4'b0 ||
        sdram_wr_addr !== 24'h0 || sdram_rd_addr !== 24'h0) begin
      bad++; $display("FAIL async_reset: got ctrl=%b addr=%0h/%0h expected 0",
                      {sdram_wr_req, sdram_rd_req, wr_fifo_flush, rd_fifo_flush},
                      sdram_wr_addr, sdram_rd_addr);
    end
    sdram_wr_ack = 1'b0;
    wr_fifo_used = 10'd0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; sdram_init_done = 1'b0;
    wr_fifo_used = '0; rd_fifo_used = 10'd512;
    wr_burst = 10'd256; rd_burst = 10'd256;
    wr_min_addr = 24'h0;    wr_max_addr = 24'd768;
    rd_min_addr = 24'h1000; rd_max_addr = 24'h1300;
    wr_load = 1'b0; rd_load = 1'b0; read_valid = 1'b0;
    sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0;
    test_reset();
    test_init();
    test_wrap();
    test_priority();
    test_load_run();
    test_load_req();
    test_block_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
